// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache with 4-word (128-bit) lines and a stall-based refill FSM.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t                  state, state_nxt;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [127:0]            data_mem [LINES];
  logic [27:0]             miss_blk;
  logic [1:0]              offset;
  logic [INDEX_BITS-1:0]   idx;
  logic [INDEX_BITS-1:0]   miss_idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic                    miss_start;
  logic                    unused_addr_bits;

  assign offset           = ADDRESS[3:2];
  assign idx              = ADDRESS[4 +: INDEX_BITS];
  assign tag              = ADDRESS[31:4+INDEX_BITS];
  assign miss_idx         = miss_blk[INDEX_BITS-1:0];
  assign unused_addr_bits = ^ADDRESS[1:0];
  assign hit              = valid[idx] && (tag_mem[idx] == tag);

  // Outputs are forced quiet while reset is held, independent of array contents.
  assign READDATA    = RESET_N ? data_mem[idx][{offset, 5'd0} +: 32] : 32'd0;
  assign MEM_ADDRESS = miss_blk;

  always_comb begin
    state_nxt  = state;
    BUSYWAIT   = 1'b0;
    MEM_READ   = 1'b0;
    miss_start = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = !hit;
        if (!hit) begin
          miss_start = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        MEM_READ = 1'b1;
        BUSYWAIT = 1'b1;
        if (!MEM_BUSYWAIT) state_nxt = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!RESET_N) begin
      BUSYWAIT = 1'b0;
      MEM_READ = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      valid    <= '0;
      miss_blk <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) miss_blk <= ADDRESS[31:4];
      if (state == UPDATE) valid[miss_idx] <= 1'b1;
    end
  end

  // Line payload carries no reset; the valid bit alone qualifies it.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_mem[miss_idx] <= MEM_READDATA;
      tag_mem[miss_idx]  <= miss_blk[27:INDEX_BITS];
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && hit) hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start)           miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt;
  assign MISS_COUNT = miss_cnt;
`else
  assign HIT_COUNT  = 32'd0;
  assign MISS_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: a latency-5 memory model whose instruction word at byte address a is a+0x13.
module tb_icache_controller;

  localparam int LAT = 5;

  logic         CLK;
  logic         RESET_N;
  logic [31:0]  ADDRESS;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;

  int errors = 0;
  int checks = 0;
  int fcnt   = 0;

  icache_controller #(.INDEX_BITS(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDRESS(ADDRESS), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: busy from the first FETCH cycle until the LAT-th, data always presented.
  logic [31:0] blk_base;
  assign blk_base     = {MEM_ADDRESS, 4'b0000};
  assign MEM_BUSYWAIT = MEM_READ && (fcnt != LAT - 1);
  assign MEM_READDATA = {blk_base + 32'h1F, blk_base + 32'h1B, blk_base + 32'h17, blk_base + 32'h13};

  always @(posedge CLK) begin
    if (!MEM_READ) fcnt <= 0;
    else           fcnt <= fcnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts a fetch that must miss, follows it through FETCH/UPDATE and ends in the first hit cycle.
  task automatic do_miss(input logic [31:0] a);
    int n;
    ADDRESS = a;
    #1;
    check("miss_busy_now", {31'd0, BUSYWAIT}, 32'd1);
    check("miss_memread_idle", {31'd0, MEM_READ}, 32'd0);
    @(negedge CLK);
    n = 0;
    while (MEM_READ && n < 50) begin
      check("fetch_mem_addr", {4'd0, MEM_ADDRESS}, {4'd0, a[31:4]});
      check("fetch_busy", {31'd0, BUSYWAIT}, 32'd1);
      n++;
      @(negedge CLK);
    end
    check("fetch_cycles", n, LAT);
    check("update_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    check("after_fill_busy", {31'd0, BUSYWAIT}, 32'd0);
    check("after_fill_data", READDATA, a + 32'h13);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        exp_busy;
    logic [31:0] exp_data;
    logic        exp_memread;
  } vec_t;

  vec_t vecs [3];
  logic [31:0] exp_hits, exp_misses;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0004, 1'b0, 32'h0000_0017, 1'b0};
    vecs[1] = '{32'h0000_0008, 1'b0, 32'h0000_001B, 1'b0};
    vecs[2] = '{32'h0000_000C, 1'b0, 32'h0000_001F, 1'b0};

    RESET_N = 1'b0;
    ADDRESS = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
    check("rst_memread", {31'd0, MEM_READ}, 32'd0);
    check("rst_readdata", READDATA, 32'd0);
    check("rst_mem_addr", {4'd0, MEM_ADDRESS}, 32'd0);
    check("rst_hits", HIT_COUNT, 32'd0);
    check("rst_misses", MISS_COUNT, 32'd0);

    // Cold miss at 0x0 followed by three sequential hits.
    RESET_N = 1'b1;
    do_miss(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      ADDRESS = vecs[i].addr;
      #1;
      check("seq_busy", {31'd0, BUSYWAIT}, {31'd0, vecs[i].exp_busy});
      check("seq_data", READDATA, vecs[i].exp_data);
      check("seq_memread", {31'd0, MEM_READ}, {31'd0, vecs[i].exp_memread});
      @(negedge CLK);
    end
`ifdef ICACHE_STATS_EN
    exp_hits = 32'd3;
    exp_misses = 32'd1;
`else
    exp_hits = 32'd0;
    exp_misses = 32'd0;
`endif
    check("stat_hits", HIT_COUNT, exp_hits);
    check("stat_misses", MISS_COUNT, exp_misses);

    // Byte offset bits are ignored.
    ADDRESS = 32'h0000_000E;
    #1;
    check("lowbits_busy", {31'd0, BUSYWAIT}, 32'd0);
    check("lowbits_data", READDATA, 32'h0000_001F);
    @(negedge CLK);

    // Conflict eviction on index 0.
    do_miss(32'h0000_0080);
    check("evict_mem_addr", {4'd0, MEM_ADDRESS}, 32'h0000_0008);
    do_miss(32'h0000_0000);

    // Address change mid-FETCH must not redirect the refill.
    do_miss(32'h0000_0080);
    ADDRESS = 32'h0000_0000;
    #1;
    check("chg_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    ADDRESS = 32'h0000_0040;
    for (int n = 0; n < 50 && MEM_READ; n++) begin
      check("chg_mem_addr", {4'd0, MEM_ADDRESS}, 32'd0);
      @(negedge CLK);
    end
    check("chg_update_memread", {31'd0, MEM_READ}, 32'd0);
    ADDRESS = 32'h0000_0000;
    @(negedge CLK);
    check("chg_hit_busy", {31'd0, BUSYWAIT}, 32'd0);
    check("chg_hit_data", READDATA, 32'h0000_0013);

    // Reset during FETCH.
    ADDRESS = 32'h0000_0020;
    #1;
    check("rm_busy", {31'd0, BUSYWAIT}, 32'd1);
    repeat (2) @(negedge CLK);
    check("rm_memread_pre", {31'd0, MEM_READ}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("rm_memread", {31'd0, MEM_READ}, 32'd0);
    check("rm_busy_rst", {31'd0, BUSYWAIT}, 32'd0);
    check("rm_readdata", READDATA, 32'd0);
    check("rm_mem_addr", {4'd0, MEM_ADDRESS}, 32'd0);
    check("rm_hits", HIT_COUNT, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    do_miss(32'h0000_0020);
    ADDRESS = 32'h0000_0000;
    #1;
    check("rm_line0_invalid", {31'd0, BUSYWAIT}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
